// File: rtl/pad_strap_ctrl.sv
// Strap sampling sequencer: holds strap pads as inputs, settles, debounces, then locks the
// strap values and drives the JTAG-overlay enable and bootstrap flag into the core.
module pad_strap_ctrl #(
  parameter int unsigned           NumStraps      = 2,
  parameter int unsigned           SettleCycles   = 8,
  parameter int unsigned           DebounceCycles = 16,
  parameter int unsigned           TimeoutCycles  = 1024,
  parameter logic [NumStraps-1:0]  DefaultStraps  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumStraps-1:0] strap_pad_i,
  input  logic                 sample_req_i,
  input  logic                 lc_jtag_allow_i,
  output logic [NumStraps-1:0] strap_force_in_o,
  output logic [NumStraps-1:0] strap_o,
  output logic                 strap_valid_o,
  output logic                 strap_timeout_o,
  output logic                 jtag_en_o,
  output logic                 bootstrap_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] DebLimit   = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] TmoLimit   = CntW'(TimeoutCycles);

  typedef enum logic [1:0] {StSettle, StDebounce, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [CntW-1:0]        stable_cnt_q, stable_cnt_d;
  logic [CntW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [NumStraps-1:0]   cand_q, cand_d;
  logic [NumStraps-1:0]   strap_q, strap_d;
  logic                   timeout_q, timeout_d;
  logic                   jtag_en_q, jtag_en_d;
  logic                   bootstrap_q, bootstrap_d;
  logic                   locked;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + CntW'(1);
  endfunction

  assign locked = (state_q == StLocked);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    stable_cnt_d = stable_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    cand_d       = cand_q;
    strap_d      = strap_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d      = StDebounce;
          cand_d       = strap_pad_i;
          stable_cnt_d = CntW'(1);
          tmo_cnt_d    = CntW'(1);
        end else begin
          settle_cnt_d = sat_inc(settle_cnt_q);
        end
      end
      StDebounce: begin
        // A completed debounce takes priority over a simultaneous timeout.
        if (stable_cnt_q == DebLimit) begin
          state_d   = StLocked;
          strap_d   = cand_q;
          timeout_d = 1'b0;
        end else if (tmo_cnt_q == TmoLimit) begin
          state_d   = StLocked;
          strap_d   = DefaultStraps;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          if (strap_pad_i != cand_q) begin
            cand_d       = strap_pad_i;
            stable_cnt_d = CntW'(1);
          end else begin
            stable_cnt_d = sat_inc(stable_cnt_q);
          end
        end
      end
      StLocked: ;
      default: state_d = StSettle;
    endcase

    if (sample_req_i) begin
      state_d      = StSettle;
      settle_cnt_d = '0;
      stable_cnt_d = '0;
      tmo_cnt_d    = '0;
      timeout_d    = 1'b0;
    end
  end

  assign jtag_en_d   = locked & strap_q[0] & lc_jtag_allow_i;
  assign bootstrap_d = locked & strap_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StSettle;
      settle_cnt_q <= '0;
      stable_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      cand_q       <= '0;
      strap_q      <= DefaultStraps;
      timeout_q    <= 1'b0;
      jtag_en_q    <= 1'b0;
      bootstrap_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      cand_q       <= cand_d;
      strap_q      <= strap_d;
      timeout_q    <= timeout_d;
      jtag_en_q    <= jtag_en_d;
      bootstrap_q  <= bootstrap_d;
    end
  end

  assign strap_force_in_o = locked ? '0 : '1;
  assign strap_o          = strap_q;
  assign strap_valid_o    = locked;
  assign strap_timeout_o  = timeout_q;
  assign jtag_en_o        = jtag_en_q;
  assign bootstrap_o      = bootstrap_q;

endmodule
